// File: rtl/fxp_div_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fxp_div_pipe                                                  |
// | Purpose  : Fully pipelined signed fixed-point divider Q = A / B for      |
// |            Q(WIDTH-Q_BITS).Q_BITS operands. Non-restoring radix-2 core,  |
// |            BITS_PER_STAGE quotient bits per stage, one result per clock, |
// |            global-stall backpressure, tag pass-through, saturation on    |
// |            overflow and divide-by-zero flagging.                         |
// | Ports    : clk, reset (sync, active-low)                                 |
// |            in_valid/in_ready/in_a/in_b/in_tag   operand side            |
// |            out_valid/out_ready/out_q/out_tag    result side             |
// |            out_ovf (saturated), out_dz (divisor zero)                    |
// | Options  : FXP_DIV_ROUND_EN - one guard iteration, round half away from  |
// |            zero. Undefined: truncate toward zero.                        |
// | Notes    : Q_BITS must be >= 1.                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fxp_div_pipe #(
  parameter int WIDTH          = 16,
  parameter int Q_BITS         = 12,
  parameter int BITS_PER_STAGE = 4,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  output logic             out_dz
);

`ifdef FXP_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int N      = WIDTH + Q_BITS + RND;
  localparam int STAGES = (N + BITS_PER_STAGE - 1) / BITS_PER_STAGE;

  localparam logic [WIDTH-1:0] Q_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  // Largest magnitudes representable for positive / negative results.
  localparam logic [N-1:0]     POS_LIM = {{(N-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [N-1:0]     NEG_LIM = {{(N-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  // Global stall: the whole pipe moves only when the output slot is free.
  logic advance;
  logic out_valid_q;
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // Operand conditioning. Unary minus of MIN yields MIN, which read as an
  // unsigned magnitude is exactly 2^(WIDTH-1).
  logic             a_neg_d;
  logic             b_neg_d;
  logic [WIDTH-1:0] a_mag_d;
  logic [WIDTH-1:0] b_mag_d;
  assign a_neg_d = in_a[WIDTH-1];
  assign b_neg_d = in_b[WIDTH-1];
  assign a_mag_d = a_neg_d ? -in_a : in_a;
  assign b_mag_d = b_neg_d ? -in_b : in_b;

  // Index 0 is the input register, 1..STAGES the iteration stages.
  logic [STAGES:0]              vld_q;
  logic [STAGES:0]              sgn_q;
  logic [STAGES:0]              dz_q;
  logic [STAGES:0]              az_q;
  logic [STAGES:0]              an_q;
  logic [STAGES:0][TAG_W-1:0]   tag_q;
  logic [STAGES:0][N-1:0]       quo_q;
  logic [STAGES:0][N-1:0]       quo_d;
  // The final stage's remainder is never needed, so it is not stored.
  logic [STAGES-1:0][N:0]       rem_q;
  logic [STAGES-1:0][N:0]       rem_d;
  logic [STAGES-1:0][N-1:0]     div_q;

  // Quotient register starts out holding the scaled dividend; its bits are
  // shifted into the remainder one per iteration.
  assign quo_d[0] = {a_mag_d, {(Q_BITS+RND){1'b0}}};
  assign rem_d[0] = '0;

  generate
    for (genvar s = 1; s <= STAGES; s++) begin : g_stage
      localparam int FIRST = (s - 1) * BITS_PER_STAGE;
      localparam int NS    = ((N - FIRST) < BITS_PER_STAGE) ? (N - FIRST) : BITS_PER_STAGE;
      // Last iteration overall only needs the sign of its new remainder.
      localparam int NR    = (s == STAGES) ? (NS - 1) : NS;

      logic [NR:0][N:0]   r_w;
      logic [NS:0][N-1:0] q_w;

      assign r_w[0] = rem_q[s-1];
      assign q_w[0] = quo_q[s-1];

      for (genvar j = 0; j < NS; j++) begin : g_step
        logic [N:0] sh_w;
        logic       qb_w;
        assign sh_w = {r_w[j][N-1:0], q_w[j][N-1]};
        // Quotient bit is 1 when the new remainder is non-negative.
        assign qb_w = r_w[j][N] ? ($signed(sh_w) >= -$signed({1'b0, div_q[s-1]}))
                                : ($signed(sh_w) >=  $signed({1'b0, div_q[s-1]}));
        assign q_w[j+1] = {q_w[j][N-2:0], qb_w};
        if (j < NR) begin : g_rem
          assign r_w[j+1] = r_w[j][N] ? (sh_w + {1'b0, div_q[s-1]})
                                      : (sh_w - {1'b0, div_q[s-1]});
        end
      end

      assign quo_d[s] = q_w[NS];
      if (s < STAGES) begin : g_fwd
        assign rem_d[s] = r_w[NR];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
    end else if (advance) begin
      vld_q    <= {vld_q[STAGES-1:0], in_valid};
      sgn_q    <= {sgn_q[STAGES-1:0], a_neg_d ^ b_neg_d};
      dz_q     <= {dz_q[STAGES-1:0], (in_b == '0)};
      az_q     <= {az_q[STAGES-1:0], (in_a == '0)};
      an_q     <= {an_q[STAGES-1:0], a_neg_d};
      tag_q    <= {tag_q[STAGES-1:0], in_tag};
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      div_q[0] <= {{(N-WIDTH){1'b0}}, b_mag_d};
      for (int s = 1; s < STAGES; s++) begin
        div_q[s] <= div_q[s-1];
      end
    end
  end

  // Fix-up stage: applies the guard bit (if any) to the raw magnitude.
  logic             fix_vld_q;
  logic             fix_sgn_q;
  logic             fix_dz_q;
  logic             fix_az_q;
  logic             fix_an_q;
  logic [TAG_W-1:0] fix_tag_q;
  logic [N-1:0]     fix_u_q;
  logic [N-1:0]     fix_u_d;

`ifdef FXP_DIV_ROUND_EN
  assign fix_u_d = {1'b0, quo_q[STAGES][N-1:1]} + {{(N-1){1'b0}}, quo_q[STAGES][0]};
`else
  assign fix_u_d = quo_q[STAGES];
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      fix_vld_q <= 1'b0;
    end else if (advance) begin
      fix_vld_q <= vld_q[STAGES];
      fix_sgn_q <= sgn_q[STAGES];
      fix_dz_q  <= dz_q[STAGES];
      fix_az_q  <= az_q[STAGES];
      fix_an_q  <= an_q[STAGES];
      fix_tag_q <= tag_q[STAGES];
      fix_u_q   <= fix_u_d;
    end
  end

  // Output stage: divide-by-zero handling, saturation and sign application.
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;

  always_comb begin
    res_d = fix_u_q[WIDTH-1:0];
    ovf_d = 1'b0;
    if (fix_dz_q) begin
      if (fix_az_q)      res_d = '0;
      else if (fix_an_q) res_d = Q_MIN;
      else               res_d = Q_MAX;
    end else if (!fix_sgn_q && (fix_u_q > POS_LIM)) begin
      res_d = Q_MAX;
      ovf_d = 1'b1;
    end else if (fix_sgn_q && (fix_u_q > NEG_LIM)) begin
      res_d = Q_MIN;
      ovf_d = 1'b1;
    end else if (fix_sgn_q) begin
      res_d = -fix_u_q[WIDTH-1:0];
    end
  end

  logic [WIDTH-1:0] res_q;
  logic [TAG_W-1:0] tag_res_q;
  logic             ovf_q;
  logic             dzf_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      tag_res_q   <= '0;
      ovf_q       <= 1'b0;
      dzf_q       <= 1'b0;
    end else if (advance) begin
      out_valid_q <= fix_vld_q;
      // Fields keep their last value across bubbles.
      if (fix_vld_q) begin
        res_q     <= res_d;
        tag_res_q <= fix_tag_q;
        ovf_q     <= ovf_d;
        dzf_q     <= fix_dz_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_q     = res_q;
  assign out_tag   = tag_res_q;
  assign out_ovf   = ovf_q;
  assign out_dz    = dzf_q;

endmodule
`default_nettype wire
